// File: rtl/padbus_pkg.sv
// Shared definitions for the pad-bus sequencer: state encoding, pad direction
// levels and the width of the shared phase counter.
package padbus_pkg;

  localparam int CNT_W = 4;

  localparam logic DIR_OUT = 1'b1;
  localparam logic DIR_IN  = 1'b0;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    WDIR   = 4'd1,
    WSETUP = 4'd2,
    WSTRB  = 4'd3,
    WHOLD  = 4'd4,
    WREL   = 4'd5,
    RTURN  = 4'd6,
    RSTRB  = 4'd7,
    RREL   = 4'd8
  } state_t;

endpackage

// File: rtl/padbus_seq.sv
// Core-side sequencer for a bidirectional pad bus: drives EN/DIR/data of the
// pad cells plus STB_N/RW_N, with break-before-make turnaround.
module padbus_seq
  import padbus_pkg::*;
#(
  parameter int M      = 7,
  parameter int N      = 0,
  parameter int TURN   = 1,
  parameter int WR_CYC = 2,
  parameter int RD_CYC = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ,
  input  logic       RNW,
  input  logic [M:N] WDATA,
  output logic       BUSY,
  output logic       ACK,
  output logic [M:N] RDATA,
  output logic       PAD_EN,
  output logic       PAD_DIR,
  output logic [M:N] PAD_OUT,
  input  logic [M:N] PAD_IN,
  output logic       STB_N,
  output logic       RW_N
);

  // Handshake: REQ is looked at only while the FSM sits in IDLE; once taken,
  // BUSY stays high through the single-cycle ACK and any REQ seen meanwhile
  // (including in the ACK cycle) is dropped, never queued.

  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN - 1);
  localparam logic [CNT_W-1:0] WR_LD   = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LD   = CNT_W'(RD_CYC - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  logic       en_n;
  logic       dir_n;
  logic       stb_n_n;
  logic       rw_n_n;
  logic       ack_n;
  logic       busy_n;
  logic [M:N] pad_out_n;
  logic [M:N] rdata_n;

  // Outputs are registered from the next-state decode so each pin changes on
  // the same edge that enters the state it belongs to.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      PAD_EN  <= 1'b0;
      PAD_DIR <= DIR_IN;
      STB_N   <= 1'b1;
      RW_N    <= 1'b1;
      ACK     <= 1'b0;
      BUSY    <= 1'b0;
      PAD_OUT <= '0;
      RDATA   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      PAD_EN  <= en_n;
      PAD_DIR <= dir_n;
      STB_N   <= stb_n_n;
      RW_N    <= rw_n_n;
      ACK     <= ack_n;
      BUSY    <= busy_n;
      PAD_OUT <= pad_out_n;
      RDATA   <= rdata_n;
    end
  end

  // One down-counter serves every multi-cycle phase: loaded with length-1 on
  // entry, phase ends when it reads zero.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (REQ) begin
          if (RNW) begin
            state_n = RTURN;
            cnt_n   = TURN_LD;
          end else begin
            state_n = WDIR;
          end
        end
      end
      WDIR:   state_n = WSETUP;
      WSETUP: begin
        state_n = WSTRB;
        cnt_n   = WR_LD;
      end
      WSTRB: begin
        if (cnt == '0) state_n = WHOLD;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      WHOLD:  state_n = WREL;
      WREL:   state_n = IDLE;
      RTURN: begin
        if (cnt == '0) begin
          state_n = RSTRB;
          cnt_n   = RD_LD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RSTRB: begin
        if (cnt == '0) state_n = RREL;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      RREL:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    en_n      = 1'b0;
    dir_n     = PAD_DIR;
    stb_n_n   = 1'b1;
    rw_n_n    = RW_N;
    ack_n     = 1'b0;
    busy_n    = (state_n != IDLE);
    pad_out_n = PAD_OUT;
    rdata_n   = RDATA;
    case (state_n)
      WDIR: begin
        dir_n  = DIR_OUT;
        rw_n_n = 1'b0;
      end
      WSETUP: en_n = 1'b1;
      WSTRB: begin
        en_n    = 1'b1;
        stb_n_n = 1'b0;
      end
      WHOLD: en_n = 1'b1;
      WREL:  ack_n = 1'b1;
      RTURN: begin
        dir_n  = DIR_IN;
        rw_n_n = 1'b1;
      end
      RSTRB: begin
        en_n    = 1'b1;
        stb_n_n = 1'b0;
      end
      RREL:    ack_n = 1'b1;
      default: ;
    endcase
    if (state == IDLE && REQ && !RNW) pad_out_n = WDATA;
    // Read data is taken at the close of the final strobe cycle.
    if (state == RSTRB && cnt == '0) rdata_n = PAD_IN;
  end

endmodule

// File: tb/tb_padbus_seq.sv
// Bench for padbus_seq: three instances (default, all-1 and all-15 timing)
// share stimulus and are checked cycle by cycle against a phase-length model.
module tb_padbus_seq;

  localparam int NI = 3;
  localparam int TURN_P [NI] = '{1, 1, 15};
  localparam int WR_P   [NI] = '{2, 1, 15};
  localparam int RD_P   [NI] = '{2, 1, 15};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0] req;
  logic          rnw;
  logic [7:0]    wdata;
  logic [7:0]    pad_in;

  logic [NI-1:0] busy, ack, en, dir, stb_n, rw_n;
  logic [7:0]    rdata   [NI];
  logic [7:0]    pad_out [NI];

  padbus_seq #(.M(7), .N(0), .TURN(1), .WR_CYC(2), .RD_CYC(2)) u0 (
    .CLK(clk), .RESET(rst), .REQ(req[0]), .RNW(rnw), .WDATA(wdata),
    .BUSY(busy[0]), .ACK(ack[0]), .RDATA(rdata[0]), .PAD_EN(en[0]),
    .PAD_DIR(dir[0]), .PAD_OUT(pad_out[0]), .PAD_IN(pad_in),
    .STB_N(stb_n[0]), .RW_N(rw_n[0]));

  padbus_seq #(.M(7), .N(0), .TURN(1), .WR_CYC(1), .RD_CYC(1)) u1 (
    .CLK(clk), .RESET(rst), .REQ(req[1]), .RNW(rnw), .WDATA(wdata),
    .BUSY(busy[1]), .ACK(ack[1]), .RDATA(rdata[1]), .PAD_EN(en[1]),
    .PAD_DIR(dir[1]), .PAD_OUT(pad_out[1]), .PAD_IN(pad_in),
    .STB_N(stb_n[1]), .RW_N(rw_n[1]));

  padbus_seq #(.M(7), .N(0), .TURN(15), .WR_CYC(15), .RD_CYC(15)) u2 (
    .CLK(clk), .RESET(rst), .REQ(req[2]), .RNW(rnw), .WDATA(wdata),
    .BUSY(busy[2]), .ACK(ack[2]), .RDATA(rdata[2]), .PAD_EN(en[2]),
    .PAD_DIR(dir[2]), .PAD_OUT(pad_out[2]), .PAD_IN(pad_in),
    .STB_N(stb_n[2]), .RW_N(rw_n[2]));

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rdata [NI];
  logic [7:0] exp_pout  [NI];
  logic       exp_dir   [NI];
  logic       exp_rwn   [NI];
  logic       prev_en   [NI];
  logic       prev_dir  [NI];
  logic [7:0] pin_hist  [0:63];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int i, input logic r);
    return r ? TURN_P[i] + RD_P[i] + 1 : WR_P[i] + 4;
  endfunction

  // Expected {en, dir, stb_n, rw_n, ack, busy} in cycle k after the REQ cycle.
  function automatic logic [5:0] exp_vec(input int i, input logic r, input int k);
    if (k > lat(i, r)) return {1'b0, exp_dir[i], 1'b1, exp_rwn[i], 1'b0, 1'b0};
    if (!r) begin
      if (k == 1)             return 6'b0_1_1_0_0_1;
      if (k == 2)             return 6'b1_1_1_0_0_1;
      if (k <= 2 + WR_P[i])   return 6'b1_1_0_0_0_1;
      if (k == 3 + WR_P[i])   return 6'b1_1_1_0_0_1;
      return 6'b0_1_1_0_1_1;
    end
    if (k <= TURN_P[i])           return 6'b0_0_1_1_0_1;
    if (k <= TURN_P[i] + RD_P[i]) return 6'b1_0_0_1_0_1;
    return 6'b0_0_1_1_1_1;
  endfunction

  task automatic check_cycle(input int k, input logic r);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("ctl%0d_k%0d", i, k),
          {en[i], dir[i], stb_n[i], rw_n[i], ack[i], busy[i]}, exp_vec(i, r, k));
      if (r && k == lat(i, r)) exp_rdata[i] = pin_hist[TURN_P[i] + RD_P[i]];
      chk($sformatf("rdata%0d_k%0d", i, k), rdata[i], exp_rdata[i]);
      chk($sformatf("pout%0d_k%0d", i, k), pad_out[i], exp_pout[i]);
      if (dir[i] !== prev_dir[i]) chk($sformatf("dir_turn%0d", i), {prev_en[i], en[i]}, 0);
      if (stb_n[i] === 1'b0) chk($sformatf("stb_en%0d", i), en[i], 1);
      prev_en[i]  = en[i];
      prev_dir[i] = dir[i];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      exp_rdata[i] = '0;
      exp_pout[i]  = '0;
      exp_dir[i]   = 1'b0;
      exp_rwn[i]   = 1'b1;
      prev_en[i]   = 1'b0;
      prev_dir[i]  = 1'b0;
    end
  endtask

  // Asynchronous reset between clock edges, checked before any edge arrives.
  task automatic mid_reset();
    req = '0;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_en%0d", i), en[i], 0);
      chk($sformatf("rst_stb%0d", i), stb_n[i], 1);
      chk($sformatf("rst_busy%0d", i), busy[i], 0);
      chk($sformatf("rst_ack%0d", i), ack[i], 0);
      chk($sformatf("rst_rdata%0d", i), rdata[i], 0);
      chk($sformatf("rst_pout%0d", i), pad_out[i], 0);
      chk($sformatf("rst_dir%0d", i), dir[i], 0);
      chk($sformatf("rst_rwn%0d", i), rw_n[i], 1);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check_cycle(100, 1'b0);
    end
  endtask

  // driver: one transaction on all instances; pin_fix < 0 means random pad data
  task automatic run_txn(input logic r, input logic [7:0] wd, input int pin_fix,
                         input bit noise, input int abort_at);
    int maxlen;
    @(posedge clk);
    #1;
    req    = '1;
    rnw    = r;
    wdata  = wd;
    pad_in = (pin_fix >= 0) ? 8'(pin_fix) : 8'($urandom);
    pin_hist[0] = pad_in;
    maxlen = 0;
    for (int i = 0; i < NI; i++) begin
      if (lat(i, r) > maxlen) maxlen = lat(i, r);
      if (!r) begin
        exp_pout[i] = wd;
        exp_dir[i]  = 1'b1;
        exp_rwn[i]  = 1'b0;
      end else begin
        exp_dir[i]  = 1'b0;
        exp_rwn[i]  = 1'b1;
      end
    end
    for (int k = 1; k <= maxlen; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++)
        req[i] = noise && (k <= lat(i, r)) &&
                 ((k == lat(i, r)) || ($urandom_range(0, 2) == 0));
      rnw    = 1'($urandom_range(0, 1));
      wdata  = 8'($urandom);
      pad_in = (pin_fix >= 0) ? 8'(pin_fix) : 8'($urandom);
      pin_hist[k] = pad_in;
      @(negedge clk);
      check_cycle(k, r);
      if (k == abort_at) begin
        mid_reset();
        return;
      end
    end
    req = '0;
  endtask

  initial begin
    req    = '0;
    rnw    = 1'b0;
    wdata  = '0;
    pad_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cycle(100, 1'b0);
    rst = 1'b0;

    run_txn(1'b0, 8'hA5, -1, 1'b0, 0);
    run_txn(1'b1, 8'h00, 8'h3C, 1'b0, 0);
    run_txn(1'b0, 8'h96, -1, 1'b1, 0);
    run_txn(1'b0, 8'h69, -1, 1'b1, 0);
    run_txn(1'b1, 8'h00, -1, 1'b1, 0);
    for (int n = 0; n < 12; n++)
      run_txn(1'($urandom_range(0, 1)), 8'($urandom), -1, 1'($urandom_range(0, 1)), 0);
    run_txn(1'b1, 8'h00, 8'hC3, 1'b0, 0);
    run_txn(1'b0, 8'h5A, -1, 1'b0, 3);
    run_txn(1'b0, 8'h81, -1, 1'b1, 0);
    run_txn(1'b1, 8'h00, -1, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/padbus_seq.md
Name: padbus_seq

Overview:
- Core-side sequencer for an external bidirectional data bus built from padbi_invin_invout_p cells.
- Drives the cells' EN/DIR controls and pad output data, and captures pad input data.
- Generates the external strobe and read/write line for each transfer.
- Guarantees break-before-make bus turnaround: DIR never changes while EN=1.
- Core side uses a single-request / single-ACK handshake.

Parameters:
- M, 7, MSB index of data bus.
- N, 0, LSB index of data bus.
- TURN, 1, idle cycles (EN=0) before a read strobe; legal range 1..15.
- WR_CYC, 2, cycles STB_N held low on a write; legal range 1..15.
- RD_CYC, 2, cycles STB_N held low on a read; data sampled on the last of these; legal range 1..15.

Ports:
- CLK  input  1  single system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- REQ  input  1  transfer request; sampled only in IDLE.
- RNW  input  1  1=read, 0=write; captured with REQ.
- WDATA  input  [M:N]  write data; captured with REQ.
- BUSY  output  1  high from the cycle after REQ acceptance through the ACK cycle.
- ACK  output  1  one-cycle completion pulse.
- RDATA  output  [M:N]  read data; valid from the ACK cycle, held until the next read completes.
- PAD_EN  output  1  to pad cell EN.
- PAD_DIR  output  1  to pad cell DIR; 1=outbound (core to pin), 0=inbound.
- PAD_OUT  output  [M:N]  to pad BISIG when outbound.
- PAD_IN  input  [M:N]  from pad BISIG when inbound.
- STB_N  output  1  external strobe, active low.
- RW_N  output  1  external direction line; 1=read, 0=write.

Behaviour:
- All outputs are registered. State changes on the CLK rising edge.
- Reset (asynchronous, any time, including mid-transfer) forces: state IDLE, PAD_EN=0, PAD_DIR=0, STB_N=1, RW_N=1, ACK=0, BUSY=0, RDATA=0, PAD_OUT=0, counter=0. The transfer in progress is abandoned; no ACK is issued.
- IDLE: PAD_EN=0, STB_N=1; PAD_DIR and RW_N hold their previous values.
  - REQ=1 and RNW=0: capture WDATA into PAD_OUT, go to WDIR.
  - REQ=1 and RNW=1: go to RTURN.
- Write sequence:
  - WDIR (1 cycle): PAD_DIR=1, PAD_EN=0, RW_N=0.
  - WSETUP (1 cycle): PAD_EN=1.
  - WSTRB (WR_CYC cycles): STB_N=0.
  - WHOLD (1 cycle): STB_N=1, PAD_EN stays 1.
  - WREL (1 cycle): PAD_EN=0, ACK=1. PAD_DIR stays 1.
  - Then IDLE.
  - Write latency, REQ edge to ACK: WR_CYC+4 cycles.
- Read sequence:
  - RTURN (TURN cycles): PAD_DIR=0, PAD_EN=0, RW_N=1.
  - RSTRB (RD_CYC cycles): PAD_EN=1, STB_N=0. RDATA<=PAD_IN on the last RSTRB cycle.
  - RREL (1 cycle): STB_N=1, PAD_EN=0, ACK=1.
  - Then IDLE.
  - Read latency: TURN+RD_CYC+1 cycles.
- Invariants:
  - PAD_DIR changes only in a cycle where PAD_EN is 0 both before and after the change.
  - STB_N=0 only while PAD_EN=1.
- A single 4-bit down-counter is shared by RTURN, WSTRB and RSTRB. It loads param-1 on state entry and the state exits when the counter reaches 0.
- REQ while BUSY is ignored; it is not queued.
- REQ in the cycle ACK is high is also ignored. A new request is accepted only once the FSM is back in IDLE.
- Back-to-back write then read: the RTURN gap of TURN cycles with EN=0 is always inserted. Consecutive writes skip no state; WDIR is always executed.

Decomposition:
- Shared package padbus_pkg holds:
  - state encoding constants: IDLE, WDIR, WSETUP, WSTRB, WHOLD, WREL, RTURN, RSTRB, RREL (4-bit);
  - DIR_OUT=1 and DIR_IN=0;
  - counter width CNT_W=4.
- No sub-module. The FSM, counter and data registers live in one module.
- Pad cells are instantiated by the parent, not inside padbus_seq.

Test Plan:
- Reset: RESET=1 asynchronously mid-WSTRB -> same instant PAD_EN=0, STB_N=1, BUSY=0, RDATA=0; no ACK after release.
- Write, defaults, WDATA=8'hA5: PAD_OUT=8'hA5. PAD_DIR rises one cycle before PAD_EN. STB_N is low for exactly 2 cycles. ACK occurs 6 cycles after REQ, with PAD_EN=0 in the ACK cycle.
- Read, TURN=1, RD_CYC=2, PAD_IN=8'h3C during the strobe: RDATA=8'h3C at ACK, 4 cycles after REQ. PAD_DIR=0 for at least 1 cycle before PAD_EN rises.
- Write immediately followed by read (REQ on the cycle after ACK): PAD_EN=0 for at least TURN+1 cycles across the DIR 1->0 change. Assert each cycle that DIR never toggles while EN=1.
- REQ pulsed during BUSY and in the ACK cycle -> ignored: exactly one ACK; PAD_OUT and RW_N unchanged.
- Parameter sweep with WR_CYC=RD_CYC=TURN=1 and with 15 -> strobe widths of 1 and 15 cycles respectively; latencies match the formulas.
